// File: rtl/jtframe_ram_dma.sv
// jtframe_ram_dma -- moves a block of words into the port 0 side of a
// jtframe_dual_ram. Each word is either copied from a slow source (SDRAM or
// ROM, with a req/ack handshake) or taken from a constant, so the same
// engine can load a RAM or clear it.
//
// Sequencing is a four-state machine: IDLE, READ, WRITE and DONE.
// - ram_we, src_req, busy and done are flops.
// - The address and data outputs are decoded only from latched operands and
//   the word counter, so no input reaches an output through logic alone.
// - Every register clears on reset, so all outputs read zero during reset.
module jtframe_ram_dma #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int SW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
    input  logic [SW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic [SW-1:0] src_addr,
    output logic          src_req,
    input  logic          src_ack,
    input  logic [DW-1:0] src_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [AW:0]   count_reg;
    logic [AW:0]   len_reg;
    logic [SW-1:0] src_base_reg;
    logic [AW-1:0] dst_base_reg;
    logic          fill_reg;
    logic [DW-1:0] fill_val_reg;
    logic [DW-1:0] data_reg;

    logic src_req_next, ram_we_next, busy_next, done_next;
    logic accept, ack_seen, last_word;

    // A start only counts in IDLE and never alongside abort.
    assign accept = (state_reg == ST_IDLE) && start && !abort;

    // An ack counts only while a request is actually outstanding.
    assign ack_seen = (state_reg == ST_READ) && src_req && src_ack;

    // The word being written now is the last one of the block.
    // count+1 cannot overflow: the counter never exceeds len-1 here.
    assign last_word = (count_reg + {{AW{1'b0}}, 1'b1}) == len_reg;

    // State and handshake flags: the flags follow the state being entered,
    // so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            src_req   <= 1'b0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_req   <= src_req_next;
            ram_we    <= ram_we_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next-state decision; abort overrides everything and drops back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_next = ST_DONE;
                    else if (fill)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (ack_seen)
                    state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word)
                    state_next = ST_DONE;
                else if (fill_reg)
                    state_next = ST_WRITE;
                else
                    state_next = ST_READ;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (abort)
            state_next = ST_IDLE;
    end

    // Output flag decode. Done is taken from the DONE state one cycle later,
    // so it shows while the machine is already back in IDLE. An abort in
    // DONE suppresses the pulse.
    always_comb begin
        src_req_next = (state_next == ST_READ);
        ram_we_next  = (state_next == ST_WRITE);
        busy_next    = (state_next == ST_READ) || (state_next == ST_WRITE);
        done_next    = (state_reg == ST_DONE) && !abort;
    end

    // Operand latch, source data capture and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            len_reg      <= '0;
            src_base_reg <= '0;
            dst_base_reg <= '0;
            fill_reg     <= 1'b0;
            fill_val_reg <= '0;
            data_reg     <= '0;
        end else begin
            if (accept) begin
                count_reg    <= '0;
                len_reg      <= len;
                src_base_reg <= src_base;
                dst_base_reg <= dst_base;
                fill_reg     <= fill;
                fill_val_reg <= fill_val;
            end
            if (ack_seen && !abort)
                data_reg <= src_data;
            if ((state_reg == ST_WRITE) && !abort)
                count_reg <= count_reg + {{AW{1'b0}}, 1'b1};
        end
    end

    // Both address sums wrap naturally at their own widths.
    assign src_addr = src_base_reg + SW'(count_reg);
    assign ram_addr = dst_base_reg + count_reg[AW-1:0];
    assign ram_data = fill_reg ? fill_val_reg : data_reg;

endmodule

// File: tb/tb_jtframe_ram_dma.sv
// Bench for jtframe_ram_dma.
// The source side is a responder with a per-request latency. Source contents
// come from a hash of the word address. A negedge monitor logs every RAM
// write, done pulse and request cycle.
// Expected writes are worked out from the transfer operands with plain
// modular arithmetic.
module tb_jtframe_ram_dma;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int SW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fill = 1'b0;
    logic [DW-1:0] fill_val = '0;
    logic [SW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic [SW-1:0] src_addr;
    logic          src_req;
    logic          src_ack;
    logic [DW-1:0] src_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic          busy;
    logic          done;

    jtframe_ram_dma #(.DW(DW), .AW(AW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fill(fill),
        .fill_val(fill_val), .src_base(src_base), .dst_base(dst_base),
        .len(len), .abort(abort), .src_addr(src_addr), .src_req(src_req),
        .src_ack(src_ack), .src_data(src_data), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source memory contents: a fixed hash of the word address.
    function automatic logic [DW-1:0] src_word(input logic [SW-1:0] a);
        logic [31:0] x;
        x = {10'd0, a} * 32'h9E3779B1;
        return x[23:16] ^ a[7:0];
    endfunction

    // Source responder controls, plus a manual ack path for late-ack cases.
    logic          resp_en = 1'b1;
    logic          resp_ack = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic          man_ack = 1'b0;
    logic [DW-1:0] man_data = '0;
    int            lat_q[$];
    int            max_lat = 3;
    int            cur_lat = 0;
    int            wcnt = 0;
    bit            acked = 1'b0;
    bit            picked = 1'b0;

    assign src_ack  = resp_ack | man_ack;
    assign src_data = man_ack ? man_data : resp_data;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    wr_t           wr_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            req_cyc = 0;
    int            stab_err = 0;
    logic          prev_req = 1'b0;
    logic [SW-1:0] prev_addr = '0;
    int            start_cyc = 0;

    // Monitor first (sees this cycle's outputs and the ack in effect), then
    // responder.
    always @(negedge clk) begin
        if (ram_we) wr_q.push_back(wr_t'{a: ram_addr, d: ram_data, c: cyc});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (src_req) req_cyc++;
        if (src_req && prev_req && src_addr !== prev_addr) stab_err++;
        prev_req  = src_req;
        prev_addr = src_addr;

        resp_ack = 1'b0;
        if (!src_req) begin
            acked  = 1'b0;
            picked = 1'b0;
            wcnt   = 0;
        end else begin
            if (!picked) begin
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                else cur_lat = $urandom_range(0, max_lat);
                picked = 1'b1;
            end
            if (resp_en && !acked) begin
                if (wcnt >= cur_lat) begin
                    resp_ack  = 1'b1;
                    resp_data = src_word(src_addr);
                    acked     = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit f, input logic [DW-1:0] fv, input logic [SW-1:0] sb,
                               input logic [AW-1:0] db, input logic [AW:0] ln);
        fill      = f;
        fill_val  = fv;
        src_base  = sb;
        dst_base  = db;
        len       = ln;
        start     = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        tick(2);
        chk({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input string tag, input bit f, input logic [DW-1:0] fv,
                                input logic [SW-1:0] sb, input logic [AW-1:0] db, input int ln);
        logic [AW-1:0] ea;
        logic [SW-1:0] sa;
        logic [DW-1:0] ed;
        chk({tag, " write count"}, 64'(wr_q.size()), 64'(ln));
        for (int i = 0; i < wr_q.size() && i < ln; i++) begin
            ea = db + AW'(i);
            sa = sb + SW'(i);
            ed = f ? fv : src_word(sa);
            chk($sformatf("%s addr[%0d]", tag, i), 64'(wr_q[i].a), 64'(ea));
            chk($sformatf("%s data[%0d]", tag, i), 64'(wr_q[i].d), 64'(ed));
            if (f && i > 0)
                chk($sformatf("%s back-to-back[%0d]", tag, i), 64'(wr_q[i].c - wr_q[i-1].c), 64'd1);
        end
    endtask

    task automatic run_xfer(input string tag, input bit f, input logic [DW-1:0] fv,
                            input logic [SW-1:0] sb, input logic [AW-1:0] db, input int ln);
        int d0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start(f, fv, sb, db, (AW+1)'(ln));
        wait_done(tag, d0, ln * (max_lat + 4) + 20);
        check_writes(tag, f, fv, sb, db, ln);
        $display("xfer %s fill=%0d fv=%0h src=%0h dst=%0h len=%0d writes=%0d",
                 tag, f, fv, sb, db, ln, wr_q.size());
    endtask

    // Hard stop in case a wait is ever left unbounded by mistake.
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, k;

        // Reset state.
        tick(3);
        chk("reset src_req", 64'(src_req), 64'd0);
        chk("reset ram_we", 64'(ram_we), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset src_addr", 64'(src_addr), 64'd0);
        chk("reset ram_addr", 64'(ram_addr), 64'd0);
        chk("reset ram_data", 64'(ram_data), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Fill across the top of the RAM: 0x3FE, 0x3FF, 0x000, 0x001.
        run_xfer("fill wrap", 1'b1, 8'hA5, '0, 10'h3FE, 4);
        if (wr_q.size() == 4) begin
            chk("fill wrap first write latency", 64'(wr_q[0].c - start_cyc), 64'd1);
            chk("fill wrap done after last write", 64'(done_cyc - wr_q[3].c), 64'd2);
        end

        // Copy with ack latencies 0, 5, 2.
        lat_q = '{0, 5, 2};
        run_xfer("copy lat 0/5/2", 1'b0, '0, 22'h000100, 10'h040, 3);

        // Zero length: no request, no write, done two cycles after start.
        wr_q.delete();
        d0 = done_cnt;
        r0 = req_cyc;
        pulse_start(1'b0, '0, 22'h000123, 10'h010, '0);
        wait_done("len0", d0, 10);
        chk("len0 writes", 64'(wr_q.size()), 64'd0);
        chk("len0 src_req cycles", 64'(req_cyc - r0), 64'd0);
        chk("len0 done latency", 64'(done_cyc - start_cyc), 64'd2);
        $display("xfer len0 done_latency=%0d", done_cyc - start_cyc);

        // Abort with an ack outstanding; the ack shows up one cycle late.
        resp_en = 1'b0;
        wr_q.delete();
        d0 = done_cnt;
        pulse_start(1'b0, '0, 22'h002000, 10'h050, 11'd4);
        tick(2);
        chk("abort pre src_req", 64'(src_req), 64'd1);
        chk("abort pre busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick(1);
        abort    = 1'b0;
        man_data = 8'h5A;
        man_ack  = 1'b1;
        chk("abort src_req dropped", 64'(src_req), 64'd0);
        chk("abort busy dropped", 64'(busy), 64'd0);
        tick(1);
        man_ack = 1'b0;
        tick(6);
        chk("abort writes", 64'(wr_q.size()), 64'd0);
        chk("abort done pulses", 64'(done_cnt - d0), 64'd0);
        chk("abort busy idle", 64'(busy), 64'd0);
        $display("xfer abort writes=%0d done=%0d", wr_q.size(), done_cnt - d0);
        resp_en = 1'b1;
        run_xfer("after abort", 1'b0, '0, 22'h002000, 10'h050, 4);

        // Start pulsed while busy must be ignored.
        wr_q.delete();
        d0 = done_cnt;
        pulse_start(1'b1, 8'h3C, '0, 10'h010, 11'd6);
        tick(2);
        pulse_start(1'b1, 8'hC3, 22'h0000FF, 10'h200, 11'd2);
        wait_done("start while busy", d0, 40);
        check_writes("start while busy", 1'b1, 8'h3C, '0, 10'h010, 6);
        $display("xfer start-while-busy writes=%0d", wr_q.size());

        // Source address wraps at 2^SW.
        run_xfer("src wrap", 1'b0, '0, 22'h3FFFFE, 10'h100, 4);

        // Asynchronous reset in the middle of a copy.
        wr_q.delete();
        pulse_start(1'b0, '0, 22'h000400, 10'h3F0, 11'd8);
        k = 0;
        while (wr_q.size() < 2 && k < 60) begin
            tick(1);
            k++;
        end
        chk("reset-mid reached writes", 64'(wr_q.size() >= 2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset-mid src_req", 64'(src_req), 64'd0);
        chk("reset-mid ram_we", 64'(ram_we), 64'd0);
        chk("reset-mid busy", 64'(busy), 64'd0);
        chk("reset-mid src_addr", 64'(src_addr), 64'd0);
        chk("reset-mid ram_addr", 64'(ram_addr), 64'd0);
        chk("reset-mid ram_data", 64'(ram_data), 64'd0);
        tick(2);
        rst_n = 1'b1;
        wr_q.delete();
        d0 = done_cnt;
        tick(20);
        chk("reset-mid writes after release", 64'(wr_q.size()), 64'd0);
        chk("reset-mid done after release", 64'(done_cnt - d0), 64'd0);
        $display("xfer reset-mid writes_after=%0d", wr_q.size());

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            run_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), DW'($urandom),
                     SW'($urandom), AW'($urandom), $urandom_range(0, 24));
        end

        // Full-size fill, 2^AW words.
        run_xfer("full fill", 1'b1, 8'h77, '0, 10'h123, 1 << AW);

        chk("src_addr stable while req", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
